shiftreg_universal: RTL and testbench
=====================================

Name: shiftreg_universal

Overview:
Parametrised universal shift register, successor to the single-mode left shifter. It supports a per-cycle mode for hold, parallel load, logical left and right shift, and arithmetic right shift, with independent serial inputs and outputs at both ends. A built-in frame counter tracks shifts since the last load and flags a complete N-bit serial frame. It sits in the datapath beside the ALU for serial I/O and shift-by-one sequencing.

Parameters:
N, `SHIFT_LEN, register width in bits; legal range 2..64.
CW, $clog2(N+1), frame counter width; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high; clears all state
en  in  1  cycle enable; when 0, the register and counter hold regardless of mode
mode  in  3  operation select; encodings listed under Behaviour
sin_l  in  1  serial input shifted into bit 0 on shift-left
sin_r  in  1  serial input shifted into bit N-1 on logical shift-right
data_in  in  N  parallel load value
data_out  out  N  register contents
sout_l  out  1  data_out[N-1], combinational
sout_r  out  1  data_out[0], combinational
shift_cnt  out  CW  number of shifts since the last load or reset, saturating at N
frame_done  out  1  one-cycle pulse on the shift that makes shift_cnt reach N
busy  out  1  high when 0 < shift_cnt < N, combinational from shift_cnt

Behaviour:
- Reset is asynchronous and active-high: data_out=0, shift_cnt=0, frame_done=0. Reset asserted mid-frame aborts the frame; frame_done does not fire.
- Mode encodings (shared package):
  - 000 HOLD
  - 001 LOAD: data_out<=data_in
  - 010 SHL: {data_out[N-2:0],sin_l}
  - 011 SHR: {sin_r,data_out[N-1:1]}
  - 100 SAR: {data_out[N-1],data_out[N-1:1]}
  - 101 ROL, 110 ROR: see Optional Feature
  - 111 CLR: data_out<=0
- Latency: one cycle. The new data_out is visible after the rising edge. sout_l and sout_r follow data_out combinationally.
- Counter rules, applied only when en=1:
  - LOAD or CLR: shift_cnt<=0.
  - Any shift mode (SHL/SHR/SAR/ROL/ROR): shift_cnt<=min(shift_cnt+1, N).
  - HOLD: counter unchanged.
- frame_done is registered. It is 1 in the cycle after the edge where shift_cnt goes from N-1 to N. It is 0 otherwise, including on shifts while already saturated at N.
- en=0 with any mode: no state change, and frame_done<=0.
- Boundary conditions:
  - LOAD in the same cycle the counter would reach N: LOAD wins, shift_cnt=0, no frame_done.
  - Mixing shift directions within a frame still counts each shift.
  - Unrecognised encodings cannot occur (3-bit space fully decoded).

Optional Feature:
Macro SHIFTREG_ROTATE_EN.
- Defined:
  - ROL (101): {data_out[N-2:0],data_out[N-1]}
  - ROR (110): {data_out[0],data_out[N-1:1]}
  - Both count as shifts.
- Undefined: 101 and 110 behave exactly as HOLD, and the counter is unchanged.

Decomposition:
- Package shiftreg_pkg holds:
  - MODE_* 3-bit localparams for all eight encodings
  - a helper function for counter width
- SHIFT_LEN stays in config.v.
- One sub-module is natural: shiftreg_frame_cnt. It contains the saturating counter, the frame_done register and busy, and is driven by en, a "shift" strobe and a "clear" strobe. The next-state data mux stays in the top.

Test Plan:
1. N=8. Reset mid-operation with data_out=8'hA5 and shift_cnt=3 -> data_out=0, shift_cnt=0, frame_done=0 immediately, without waiting for a clock edge.
2. LOAD 8'hB4, then 8×SHL with sin_l=0 -> sout_l sequence 1,0,1,1,0,1,0,0 and final data_out=0. frame_done is high only in the cycle after the 8th shift; busy is high after shifts 1..7. A 9th SHL leaves shift_cnt=8 with frame_done=0.
3. LOAD 8'h90, then SAR ×2 -> 8'hE4. Then SHR with sin_r=0 -> 8'h72, shift_cnt=3.
4. LOAD 8'h81 with SHIFTREG_ROTATE_EN defined, then ROL -> 8'h03 and ROR -> 8'h81. Rebuilt without the macro, ROL leaves 8'h81 with shift_cnt unchanged.
5. LOAD 8'hFF; shift 3 times with en=0 -> data_out=8'hFF, shift_cnt=0. Then shift 7 times with en=1 and LOAD on the 8th cycle -> shift_cnt=0, no frame_done pulse.
6. CLR after 5 shifts -> data_out=0, shift_cnt=0, busy=0.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// -----------------------------------------------------------------------------
// shiftreg_pkg
// Shared definitions for the universal shift register.
//   MODE_*     : 3-bit operation encodings driven on the 'mode' port.
//   cnt_width  : width needed to hold a frame count of 0..n.
// No ports (package).
// -----------------------------------------------------------------------------
package shiftreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_SAR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ROR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // The counter must represent every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shiftreg_frame_cnt.sv
// -----------------------------------------------------------------------------
// shiftreg_frame_cnt
// Saturating count of shifts since the last load/clear, plus a registered
// one-cycle frame_done pulse on the shift that completes an N-bit frame.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   en         in   cycle enable; when low the count holds and frame_done clears
//   shift      in   strobe: current operation is a shift
//   clear      in   strobe: current operation is a load or clear (wins)
//   cnt        out  [CW-1:0] shifts since last load/clear, saturating at N
//   frame_done out  pulse after the edge where cnt goes N-1 -> N
//   busy       out  0 < cnt < N (combinational)
// -----------------------------------------------------------------------------
module shiftreg_frame_cnt #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          shift,
    input  logic          clear,
    output logic [CW-1:0] cnt,
    output logic          frame_done,
    output logic          busy
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [CW-1:0] r_cnt;
    logic          r_frame_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (en) begin
                if (clear) begin
                    r_cnt <= '0;
                end else if (shift && (r_cnt != CNT_MAX)) begin
                    r_cnt        <= r_cnt + 1'b1;
                    // Only the transition into saturation fires the pulse.
                    r_frame_done <= (r_cnt == CNT_LAST);
                end
            end
        end
    end

    assign cnt        = r_cnt;
    assign frame_done = r_frame_done;
    assign busy       = (r_cnt != '0) && (r_cnt != CNT_MAX);

endmodule

// File: rtl/shiftreg_universal.sv
// -----------------------------------------------------------------------------
// shiftreg_universal
// Universal shift register: hold, parallel load, logical shift left/right,
// arithmetic shift right, clear, and optional rotates, with serial I/O at
// both ends and a frame counter that flags a complete N-bit serial frame.
// Configuration macro:
//   SHIFTREG_ROTATE_EN  defined   -> 101 = ROL, 110 = ROR (count as shifts)
//                       undefined -> 101/110 behave as HOLD
//   SHIFT_LEN           default register width (8 if not defined elsewhere)
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high; clears all state
//   en         in   cycle enable
//   mode       in   [2:0] operation select (see shiftreg_pkg)
//   sin_l      in   serial in to bit 0 on SHL
//   sin_r      in   serial in to bit N-1 on SHR
//   data_in    in   [N-1:0] parallel load value
//   data_out   out  [N-1:0] register contents
//   sout_l     out  data_out[N-1]
//   sout_r     out  data_out[0]
//   shift_cnt  out  [CW-1:0] shifts since last load/clear, saturating at N
//   frame_done out  one-cycle pulse on completion of an N-bit frame
//   busy       out  0 < shift_cnt < N
// -----------------------------------------------------------------------------
`ifndef SHIFT_LEN
`define SHIFT_LEN 8
`endif

module shiftreg_universal
    import shiftreg_pkg::*;
#(
    parameter  int N  = `SHIFT_LEN,
    localparam int CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic          sin_l,
    input  logic          sin_r,
    input  logic [N-1:0]  data_in,
    output logic [N-1:0]  data_out,
    output logic          sout_l,
    output logic          sout_r,
    output logic [CW-1:0] shift_cnt,
    output logic          frame_done,
    output logic          busy
);

    logic [N-1:0] r_data;
    logic [N-1:0] w_next;
    logic         w_shift;
    logic         w_clear;

    always_comb begin
        w_next  = r_data;
        w_shift = 1'b0;
        w_clear = 1'b0;
        case (mode)
            MODE_HOLD: w_next = r_data;
            MODE_LOAD: begin
                w_next  = data_in;
                w_clear = 1'b1;
            end
            MODE_SHL: begin
                w_next  = {r_data[N-2:0], sin_l};
                w_shift = 1'b1;
            end
            MODE_SHR: begin
                w_next  = {sin_r, r_data[N-1:1]};
                w_shift = 1'b1;
            end
            MODE_SAR: begin
                w_next  = {r_data[N-1], r_data[N-1:1]};
                w_shift = 1'b1;
            end
`ifdef SHIFTREG_ROTATE_EN
            MODE_ROL: begin
                w_next  = {r_data[N-2:0], r_data[N-1]};
                w_shift = 1'b1;
            end
            MODE_ROR: begin
                w_next  = {r_data[0], r_data[N-1:1]};
                w_shift = 1'b1;
            end
`else
            MODE_ROL: w_next = r_data;
            MODE_ROR: w_next = r_data;
`endif
            MODE_CLR: begin
                w_next  = '0;
                w_clear = 1'b1;
            end
            default: w_next = r_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (en) begin
            r_data <= w_next;
        end
    end

    shiftreg_frame_cnt #(
        .N  (N),
        .CW (CW)
    ) u_frame_cnt (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .shift      (w_shift),
        .clear      (w_clear),
        .cnt        (shift_cnt),
        .frame_done (frame_done),
        .busy       (busy)
    );

    assign data_out = r_data;
    assign sout_l   = r_data[N-1];
    assign sout_r   = r_data[0];

endmodule

// File: tb/tb_shiftreg_universal.sv
// -----------------------------------------------------------------------------
// tb_shiftreg_universal
// Directed bench for shiftreg_universal (N=8) with a reference model that
// tracks the register and frame counter arithmetically, compared every cycle,
// plus literal expectations from hand-worked sequences.
// -----------------------------------------------------------------------------
module tb_shiftreg_universal;
    import shiftreg_pkg::*;

    localparam int N  = 8;
    localparam int CW = cnt_width(N);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [2:0]    mode = MODE_HOLD;
    logic          sin_l = 1'b0;
    logic          sin_r = 1'b0;
    logic [N-1:0]  data_in = '0;
    logic [N-1:0]  data_out;
    logic          sout_l;
    logic          sout_r;
    logic [CW-1:0] shift_cnt;
    logic          frame_done;
    logic          busy;

    int errors = 0;
    int checks = 0;

    shiftreg_universal #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .sin_l      (sin_l),
        .sin_r      (sin_r),
        .data_in    (data_in),
        .data_out   (data_out),
        .sout_l     (sout_l),
        .sout_r     (sout_r),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [N-1:0] m_data = '0;
    int           m_cnt  = 0;
    logic         m_fd   = 1'b0;

`ifdef SHIFTREG_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data <= '0;
            m_cnt  <= 0;
            m_fd   <= 1'b0;
        end else begin
            m_fd <= 1'b0;
            if (en) begin
                bit is_shift;
                is_shift = (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_SAR) ||
                           (ROT && ((mode == MODE_ROL) || (mode == MODE_ROR)));
                case (mode)
                    MODE_LOAD: m_data <= data_in;
                    MODE_CLR:  m_data <= '0;
                    MODE_SHL:  m_data <= (m_data << 1) | N'(sin_l);
                    MODE_SHR:  m_data <= (m_data >> 1) | (N'(sin_r) << (N - 1));
                    MODE_SAR:  m_data <= N'($signed(m_data) >>> 1);
                    MODE_ROL:  if (ROT) m_data <= (m_data << 1) | (m_data >> (N - 1));
                    MODE_ROR:  if (ROT) m_data <= (m_data >> 1) | (m_data << (N - 1));
                    default:   m_data <= m_data;
                endcase
                if (mode == MODE_LOAD || mode == MODE_CLR) begin
                    m_cnt <= 0;
                end else if (is_shift && m_cnt < N) begin
                    m_cnt <= m_cnt + 1;
                    m_fd  <= (m_cnt + 1 == N);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_data",  64'(data_out),   64'(m_data));
        chk("m_sout_l", 64'(sout_l),    64'(m_data[N-1]));
        chk("m_sout_r", 64'(sout_r),    64'(m_data[0]));
        chk("m_cnt",   64'(shift_cnt),  64'(m_cnt));
        chk("m_fd",    64'(frame_done), 64'(m_fd));
        chk("m_busy",  64'(busy),       64'((m_cnt > 0) && (m_cnt < N)));
    end

    // One operation, inputs held across one rising edge, returns just after it.
    task automatic op(input logic [2:0] m, input logic [N-1:0] d,
                      input logic sl, input logic sr, input logic e);
        mode = m; data_in = d; sin_l = sl; sin_r = sr; en = e;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_data", 64'(data_out), 64'h0);
        chk("rst_cnt",  64'(shift_cnt), 64'h0);
        chk("rst_fd",   64'(frame_done), 64'h0);
        reset = 1'b0;

        // 1: build A5 with cnt 3, then async reset mid-cycle
        op(MODE_LOAD, 8'h14, 0, 0, 1);
        op(MODE_SHL, '0, 1, 0, 1);
        op(MODE_SHL, '0, 0, 0, 1);
        op(MODE_SHL, '0, 1, 0, 1);
        chk("t1_pre_data", 64'(data_out), 64'hA5);
        chk("t1_pre_cnt",  64'(shift_cnt), 64'd3);
        reset = 1'b1;
        #1;
        chk("t1_async_data", 64'(data_out), 64'h0);
        chk("t1_async_cnt",  64'(shift_cnt), 64'h0);
        chk("t1_async_fd",   64'(frame_done), 64'h0);
        #3 reset = 1'b0;
        @(posedge clk); #2;

        // 2: LOAD B4, 8 x SHL, then a 9th
        begin
            logic [7:0] exp_sl;
            exp_sl = 8'b1011_0100;
            op(MODE_LOAD, 8'hB4, 0, 0, 1);
            for (int k = 0; k < 8; k++) begin
                chk("t2_sout_l", 64'(sout_l), 64'(exp_sl[7-k]));
                op(MODE_SHL, '0, 0, 0, 1);
                chk("t2_busy", 64'(busy), 64'(k < 7));
                chk("t2_fd",   64'(frame_done), 64'(k == 7));
            end
            chk("t2_data", 64'(data_out), 64'h0);
            chk("t2_cnt",  64'(shift_cnt), 64'd8);
            op(MODE_SHL, '0, 0, 0, 1);
            chk("t2_sat_cnt", 64'(shift_cnt), 64'd8);
            chk("t2_sat_fd",  64'(frame_done), 64'd0);
        end

        // 3: SAR sign fill then SHR
        op(MODE_LOAD, 8'h90, 0, 0, 1);
        op(MODE_SAR, '0, 0, 0, 1);
        op(MODE_SAR, '0, 0, 0, 1);
        chk("t3_sar", 64'(data_out), 64'hE4);
        op(MODE_SHR, '0, 0, 0, 1);
        chk("t3_shr", 64'(data_out), 64'h72);
        chk("t3_cnt", 64'(shift_cnt), 64'd3);

        // 4: rotates (or HOLD without the macro)
        op(MODE_LOAD, 8'h81, 0, 0, 1);
        op(MODE_ROL, '0, 0, 0, 1);
`ifdef SHIFTREG_ROTATE_EN
        chk("t4_rol",     64'(data_out), 64'h03);
        chk("t4_rol_cnt", 64'(shift_cnt), 64'd1);
        op(MODE_ROR, '0, 0, 0, 1);
        chk("t4_ror",     64'(data_out), 64'h81);
        chk("t4_ror_cnt", 64'(shift_cnt), 64'd2);
`else
        chk("t4_rol_hold", 64'(data_out), 64'h81);
        chk("t4_rol_cnt",  64'(shift_cnt), 64'd0);
        op(MODE_ROR, '0, 0, 0, 1);
        chk("t4_ror_hold", 64'(data_out), 64'h81);
        chk("t4_ror_cnt",  64'(shift_cnt), 64'd0);
`endif

        // 5: en=0 blocks shifts; LOAD on the 8th cycle beats frame completion
        op(MODE_LOAD, 8'hFF, 0, 0, 1);
        for (int k = 0; k < 3; k++) op(MODE_SHL, '0, 0, 0, 0);
        chk("t5_en0_data", 64'(data_out), 64'hFF);
        chk("t5_en0_cnt",  64'(shift_cnt), 64'd0);
        for (int k = 0; k < 7; k++) op(MODE_SHR, '0, 1, 1, 1);
        chk("t5_cnt7", 64'(shift_cnt), 64'd7);
        op(MODE_LOAD, 8'h3C, 0, 0, 1);
        chk("t5_load_cnt", 64'(shift_cnt), 64'd0);
        chk("t5_load_fd",  64'(frame_done), 64'd0);
        chk("t5_load_data", 64'(data_out), 64'h3C);

        // frame_done cleared by an en=0 cycle, and HOLD keeps state
        for (int k = 0; k < 8; k++) op(MODE_SAR, '0, 0, 0, 1);
        chk("t5b_fd", 64'(frame_done), 64'd1);
        op(MODE_SHL, '0, 0, 0, 0);
        chk("t5b_fd_en0", 64'(frame_done), 64'd0);
        op(MODE_HOLD, 8'hAA, 1, 1, 1);
        chk("t5b_hold_cnt", 64'(shift_cnt), 64'd8);

        // 6: CLR after 5 shifts
        op(MODE_LOAD, 8'h5A, 0, 0, 1);
        for (int k = 0; k < 5; k++) op(MODE_SHL, '0, 1, 0, 1);
        chk("t6_busy_pre", 64'(busy), 64'd1);
        op(MODE_CLR, 8'hFF, 0, 0, 1);
        chk("t6_data", 64'(data_out), 64'h0);
        chk("t6_cnt",  64'(shift_cnt), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
